seq_multiplier: RTL and testbench

//   Iterative shift-add multiplier that computes MULT/MULTU-style 2*WIDTH-bit products for the pipeline's HI/LO path.

---
 rtl/mul_pkg.sv | 15 +
 rtl/mul_step.sv | 26 ++
 rtl/seq_multiplier.sv | 106 ++++++++++
 tb/tb_seq_multiplier.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encoding and step-count sizing.
package mul_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StFix} mul_state_e;

  function automatic int unsigned n_steps(input int unsigned width, input int unsigned bpc);
    return width / bpc;
  endfunction

  // Count register must hold 0..N_STEPS.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bpc);
    return $clog2(n_steps(width, bpc) + 1);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: add (b_slice * mag_a) into the upper half, then shift right.
module mul_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        acc_i,
  input  logic [WIDTH-1:0]          mag_a_i,
  input  logic [BITS_PER_CYCLE-1:0] b_slice_i,
  output logic [2*WIDTH-1:0]        acc_o
);

  localparam int unsigned SumW = WIDTH + BITS_PER_CYCLE;

  logic [SumW-1:0]                 partial;
  logic [SumW-1:0]                 sum;
  logic [2*WIDTH+BITS_PER_CYCLE-1:0] wide;

  always_comb begin
    partial = SumW'(mag_a_i) * SumW'(b_slice_i);
    // Sum never exceeds 2^BPC * (2^WIDTH - 1), so SumW bits keep every carry.
    sum     = partial + SumW'(acc_i[2*WIDTH-1:WIDTH]);
    wide    = {sum, acc_i[WIDTH-1:0]};
    acc_o   = (2*WIDTH)'(wide >> BITS_PER_CYCLE);
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier with start/busy/done handshake and a held 2*WIDTH product.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned NSteps = n_steps(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CntW   = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CntW-1:0] LastCnt = CntW'(NSteps - 1);

  if ((BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) ||
      (WIDTH % BITS_PER_CYCLE != 0)) begin : g_param_check
    $error("seq_multiplier: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
  end

  mul_state_e           state_q;
  logic [WIDTH-1:0]     mag_a_q;
  logic [WIDTH-1:0]     mag_b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CntW-1:0]      cnt_q;
  logic                 neg_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     mag_a_d;
  logic [WIDTH-1:0]     mag_b_d;

  // -2^(WIDTH-1) negates to itself, which is the correct magnitude read as unsigned.
  always_comb begin
    mag_a_d = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b_d = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  end

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i     (acc_q),
    .mag_a_i   (mag_a_q),
    .b_slice_i (mag_b_q[BITS_PER_CYCLE-1:0]),
    .acc_o     (acc_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_d;
          mag_b_q <= mag_b_q >> BITS_PER_CYCLE;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          product_q <= neg_q ? -acc_q : acc_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench: directed timing/handshake cases on a 32/1 instance, random ops on four configs.
module tb_seq_multiplier;

  localparam int NRand = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference product straight from integer arithmetic, reduced mod 2^(2w).
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input bit s);
    logic signed [127:0] x, y, p;
    logic [63:0] mask;
    x = {96'd0, a};
    y = {96'd0, b};
    if (s && a[w-1]) x = x - (128'sd1 <<< w);
    if (s && b[w-1]) y = y - (128'sd1 <<< w);
    p = x * y;
    mask = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    return p[63:0] & mask;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    case ($urandom_range(7))
      0: return 32'd0;
      1: return m;
      2: return 32'd1 << (w - 1);
      3: return 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  // ---------------- directed instance (WIDTH 32, BITS_PER_CYCLE 1) ----------------
  logic        d_rst = 1'b1;
  logic        d_start = 1'b0;
  logic        d_sgn = 1'b0;
  logic [31:0] d_a = '0;
  logic [31:0] d_b = '0;
  logic        d_busy, d_done;
  logic [63:0] d_prod;
  logic [63:0] d_q[$];
  logic [63:0] d_held = '0;

  seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dir (
    .clk       (clk),
    .reset     (d_rst),
    .start     (d_start),
    .is_signed (d_sgn),
    .op_a      (d_a),
    .op_b      (d_b),
    .busy      (d_busy),
    .done      (d_done),
    .product   (d_prod)
  );

  always @(negedge clk) begin
    if (d_done) begin
      if (d_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d_unexpected_done: got done with product %h, required no done", d_prod);
      end else begin
        chk("d_prod", d_prod, d_q.pop_front());
      end
    end
  end

  // Called at a negedge; start is sampled at the next edge (e0). lat = edges after e0 to done.
  task automatic d_run(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input logic [63:0] exp, input int pulse_at,
                       output int lat, output int busy_n, output int held_bad);
    int n;
    d_start = 1'b1;
    d_a = a;
    d_b = b;
    d_sgn = s;
    d_q.push_back(exp);
    n = 0;
    busy_n = 0;
    held_bad = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      d_start = 1'b0;
      if (n == pulse_at) begin
        d_start = 1'b1;
        d_a = 32'd2;
        d_b = 32'd3;
        d_sgn = 1'b0;
      end
      if (d_done) break;
      if (d_busy) busy_n++;
      if (d_prod !== d_held) held_bad++;
    end
    lat = n - 1;
    d_held = exp;
  endtask

  // ---------------- random instances ----------------
  logic rst = 1'b1;

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int unsigned W   = (g == 3) ? 16 : 32;
    localparam int unsigned BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 2;
    localparam int          Lat = W / BPC + 1;

    logic           r_start = 1'b0;
    logic           r_sgn = 1'b0;
    logic [W-1:0]   r_a = '0;
    logic [W-1:0]   r_b = '0;
    logic           r_busy, r_done;
    logic [2*W-1:0] r_prod;
    logic [63:0]    q[$];
    bit             fin = 1'b0;

    seq_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) u_dut (
      .clk       (clk),
      .reset     (rst),
      .start     (r_start),
      .is_signed (r_sgn),
      .op_a      (r_a),
      .op_b      (r_b),
      .busy      (r_busy),
      .done      (r_done),
      .product   (r_prod)
    );

    always @(negedge clk) begin
      if (r_done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_unexpected_done cfg %0d: got product %h, required no done", g, r_prod);
        end else begin
          chk($sformatf("rnd_prod cfg %0d", g), 64'(r_prod), q.pop_front());
        end
      end
    end

    initial begin
      int n;
      wait (rst == 1'b0);
      @(negedge clk);
      for (int i = 0; i < NRand; i++) begin
        n = 0;
        while (r_busy && n < 200) begin
          @(negedge clk);
          n++;
        end
        if ($urandom_range(3) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
        r_a = W'(pick(W));
        r_b = W'(pick(W));
        r_sgn = 1'($urandom_range(1));
        q.push_back(ref_mul(W, 32'(r_a), 32'(r_b), r_sgn));
        r_start = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          r_start = 1'b0;
          n++;
        end while (!r_done && n < 200);
        chk($sformatf("rnd_latency cfg %0d", g), 64'(n - 1), 64'(Lat));
      end
      n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("rnd_drain cfg %0d", g), 64'(q.size()), 64'd0);
      fin = 1'b1;
    end
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bn, hb;
    logic [31:0] t_a [4];
    logic [31:0] t_b [4];
    bit          t_s [4];
    logic [63:0] t_e [4];
    t_a = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd7};
    t_b = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFD};
    t_s = '{1'b1, 1'b1, 1'b0, 1'b1};
    t_e = '{64'hFFFF_FFFF_FFFF_FFFB, 64'h4000_0000_0000_0000,
            64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFEB};

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(d_busy), 64'd0);
    chk("reset_done", 64'(d_done), 64'd0);
    chk("reset_prod", d_prod, 64'd0);
    d_rst = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Unsigned max: full latency, busy window, product held at 0 until FIX.
    d_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, lat, bn, hb);
    chk("t1_latency", 64'(lat), 64'd33);
    chk("t1_busy_cycles", 64'(bn), 64'd33);
    chk("t1_held", 64'(hb), 64'd0);
    chk("t1_busy_in_done", 64'(d_busy), 64'd0);
    @(negedge clk);
    chk("t1_done_pulse", 64'(d_done), 64'd0);

    for (int i = 0; i < 4; i++) begin
      d_run(t_a[i], t_b[i], t_s[i], t_e[i], 0, lat, bn, hb);
      chk($sformatf("t2_latency %0d", i), 64'(lat), 64'd33);
      @(negedge clk);
    end

    // Start pulsed mid-operation must be ignored.
    d_run(32'd6, 32'd7, 1'b0, 64'd42, 5, lat, bn, hb);
    chk("t3_latency", 64'(lat), 64'd33);
    chk("t3_busy_cycles", 64'(bn), 64'd33);
    chk("t3_held", 64'(hb), 64'd0);
    repeat (3) @(negedge clk);
    chk("t3_no_queue", 64'(d_busy), 64'd0);

    // Back-to-back: second start issued in the done cycle.
    d_run(32'd6, 32'd7, 1'b0, 64'd42, 0, lat, bn, hb);
    d_run(32'd9, 32'd9, 1'b0, 64'd81, 0, lat, bn, hb);
    chk("t4_latency", 64'(lat), 64'd33);
    chk("t4_busy_cycles", 64'(bn), 64'd33);
    chk("t4_held42", 64'(hb), 64'd0);
    @(negedge clk);

    // Asynchronous reset mid-operation, checked before the next edge.
    d_start = 1'b1;
    d_a = 32'd123;
    d_b = 32'd456;
    d_sgn = 1'b0;
    @(negedge clk);
    d_start = 1'b0;
    repeat (9) @(negedge clk);
    chk("t5_busy_pre_rst", 64'(d_busy), 64'd1);
    d_rst = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(d_busy), 64'd0);
    chk("t5_rst_done", 64'(d_done), 64'd0);
    chk("t5_rst_prod", d_prod, 64'd0);
    d_held = '0;
    @(negedge clk);
    d_rst = 1'b0;
    @(negedge clk);
    d_run(32'd3, 32'd4, 1'b0, 64'd12, 0, lat, bn, hb);
    chk("t5_latency", 64'(lat), 64'd33);
    chk("t5_held", 64'(hb), 64'd0);

    wait (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin);
    repeat (2) @(negedge clk);
    chk("d_drain", 64'(d_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
